// File: rtl/delaychain_meter.sv
// delaychain_meter: launches alternating edges into a delay chain and sums the
// synchronized return latency over 2^LOG_RUNS runs, with ARM/MEASURE timeouts.
module delaychain_meter #(
    parameter int CNT_W       = 16,
    parameter int LOG_RUNS    = 2,
    parameter int TIMEOUT_CYC = 4000,
    parameter int SETTLE      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      chain_ret,
    output logic                      launch_out,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout,
    output logic [CNT_W+LOG_RUNS-1:0] result
);
    localparam int RW = CNT_W + LOG_RUNS;
    localparam int IW = LOG_RUNS + 1;
    localparam logic [2:0] IDLE = 3'd0, ARM = 3'd1, LAUNCH = 3'd2,
                           MEASURE = 3'd3, ACCUM = 3'd4, DONE = 3'd5;
    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] SMAX = CNT_W'(SETTLE - 1);
    localparam logic [IW-1:0] LAST = IW'((1 << LOG_RUNS) - 1);

    logic [2:0]       state;
    logic             s1, s2;
    logic [CNT_W-1:0] quiet, arm_cnt, count;
    logic [IW-1:0]    run_idx;
    logic             same;

    assign same = s2 == launch_out;
    assign busy = state inside {ARM, LAUNCH, MEASURE, ACCUM};
    assign done = state == DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            s1         <= 1'b0;
            s2         <= 1'b0;
            launch_out <= 1'b0;
            timeout    <= 1'b0;
            result     <= '0;
            quiet      <= '0;
            arm_cnt    <= '0;
            count      <= '0;
            run_idx    <= '0;
        end else begin
            s1 <= chain_ret;
            s2 <= s1;
            case (state)
                IDLE, DONE: if (start) begin
                    result  <= '0;
                    timeout <= 1'b0;
                    run_idx <= '0;
                    quiet   <= '0;
                    arm_cnt <= '0;
                    state   <= ARM;
                end
                ARM: begin
                    arm_cnt <= arm_cnt + 1'b1;
                    quiet   <= same ? quiet + 1'b1 : '0;
                    if (same && quiet == SMAX) state <= LAUNCH;
                    else if (arm_cnt == TMAX) begin
                        timeout <= 1'b1;
                        state   <= DONE;
                    end
                end
                LAUNCH: begin
                    launch_out <= ~launch_out;
                    count      <= '0;
                    state      <= MEASURE;
                end
                MEASURE: begin
                    if (same) state <= ACCUM;
                    else if (count == TMAX) begin
                        timeout <= 1'b1;
                        result  <= result + RW'(TIMEOUT_CYC);
                        state   <= DONE;
                    end else count <= count + 1'b1;
                end
                ACCUM: begin
                    result <= result + RW'(count);
                    if (run_idx == LAST) state <= DONE;
                    else begin
                        run_idx <= run_idx + 1'b1;
                        quiet   <= '0;
                        arm_cnt <= '0;
                        state   <= ARM;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_delaychain_meter.sv
// tb_delaychain_meter: directed bench with a per-instance scoreboard checked on done rise.
module tb_delaychain_meter;
    logic clk = 0, rst = 1, st0 = 0, st2 = 0, tog = 0;
    logic cr0, cr2, lo0, busy0, done0, to0, lo2, busy2, done2, to2;
    logic [15:0] res0;
    logic [17:0] res2;
    logic [7:0] dl0 = '0, dl2 = '0;
    int mode = 0, dsel = 1;
    int checks = 0, errors = 0;
    logic dq0 = 0, dq2 = 0;

    typedef struct {int res; logic to; logic lo;} exp_t;
    exp_t q0[$], q2[$];
    exp_t e0, e2;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        dl0 <= {dl0[6:0], lo0};
        dl2 <= {dl2[6:0], lo2};
        tog <= ~tog;
    end

    // mode: 0 loopback, 1 delayed by dsel cycles, 2 stuck low, 3 toggling
    assign cr0 = mode == 0 ? lo0 : mode == 1 ? dl0[dsel-1] : mode == 2 ? 1'b0 : tog;
    assign cr2 = mode == 0 ? lo2 : mode == 1 ? dl2[dsel-1] : mode == 2 ? 1'b0 : tog;

    delaychain_meter #(.CNT_W(16), .LOG_RUNS(0), .TIMEOUT_CYC(100), .SETTLE(4)) u0 (
        .clk(clk), .rst(rst), .start(st0), .chain_ret(cr0), .launch_out(lo0),
        .busy(busy0), .done(done0), .timeout(to0), .result(res0));

    delaychain_meter #(.CNT_W(16), .LOG_RUNS(2), .TIMEOUT_CYC(100), .SETTLE(4)) u2 (
        .clk(clk), .rst(rst), .start(st2), .chain_ret(cr2), .launch_out(lo2),
        .busy(busy2), .done(done2), .timeout(to2), .result(res2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done0 && !dq0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u0_unexpected_done actual=%0d expected=none", res0);
            end else begin
                e0 = q0.pop_front();
                chk("u0_result", 32'(res0), 32'(e0.res));
                chk("u0_timeout", 32'(to0), 32'(e0.to));
                chk("u0_launch", 32'(lo0), 32'(e0.lo));
            end
        end
        dq0 = done0;
    end

    always @(negedge clk) begin
        if (done2 && !dq2) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u2_unexpected_done actual=%0d expected=none", res2);
            end else begin
                e2 = q2.pop_front();
                chk("u2_result", 32'(res2), 32'(e2.res));
                chk("u2_timeout", 32'(to2), 32'(e2.to));
                chk("u2_launch", 32'(lo2), 32'(e2.lo));
            end
        end
        dq2 = done2;
    end

    task automatic pulse(input bit w);
        @(negedge clk);
        if (w) st2 = 1; else st0 = 1;
        @(negedge clk);
        st0 = 0;
        st2 = 0;
    endtask

    task automatic wait_done(input bit w, input string nm);
        int n = 0;
        while (!(w ? done2 : done0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s_done_wait actual=timeout expected=done", nm);
        end
        @(negedge clk);
    endtask

    task automatic wait_lo2(input string nm);
        int n = 0;
        logic p;
        p = lo2;
        do begin
            @(negedge clk);
            n++;
        end while (lo2 == p && n < 500);
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL %s_launch_wait actual=none expected=edge", nm);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int tg, bad, n;
        logic p;
        repeat (3) @(negedge clk);
        chk("rst_lo0", 32'(lo0), 0);
        chk("rst_busy0", 32'(busy0), 0);
        chk("rst_done0", 32'(done0), 0);
        chk("rst_to0", 32'(to0), 0);
        chk("rst_res0", 32'(res0), 0);
        chk("rst_res2", 32'(res2), 0);
        rst = 0;
        // loopback, single run
        mode = 0;
        q0.push_back('{2, 1'b0, 1'b1});
        pulse(0);
        wait_done(0, "t1");
        // 5-cycle delay, rising then falling run
        do_reset();
        mode = 1;
        dsel = 5;
        q0.push_back('{7, 1'b0, 1'b1});
        pulse(0);
        wait_done(0, "t2a");
        q0.push_back('{7, 1'b0, 1'b0});
        pulse(0);
        wait_done(0, "t2b");
        // four runs, 3-cycle delay
        do_reset();
        dsel = 3;
        q2.push_back('{20, 1'b0, 1'b0});
        pulse(1);
        chk("t3_busy_after_start", 32'(busy2), 1);
        tg = 0;
        bad = 0;
        n = 0;
        while (!done2 && n < 1000) begin
            p = lo2;
            @(negedge clk);
            n++;
            if (lo2 != p) tg++;
            if (!done2 && !busy2) bad++;
        end
        chk("t3_busy_at_done", 32'(busy2), 0);
        chk("t3_toggles", 32'(tg), 4);
        chk("t3_busy_gaps", 32'(bad), 0);
        @(negedge clk);
        // stuck-low return: MEASURE timeout, then ARM timeout
        do_reset();
        mode = 2;
        q0.push_back('{100, 1'b1, 1'b1});
        pulse(0);
        wait_done(0, "t4a");
        q0.push_back('{0, 1'b1, 1'b1});
        pulse(0);
        wait_done(0, "t4b");
        // reset mid-MEASURE
        do_reset();
        mode = 1;
        dsel = 3;
        pulse(1);
        wait_lo2("t5");
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("t5_busy", 32'(busy2), 0);
        chk("t5_done", 32'(done2), 0);
        chk("t5_lo", 32'(lo2), 0);
        chk("t5_res", 32'(res2), 0);
        rst = 0;
        mode = 0;
        q2.push_back('{8, 1'b0, 1'b0});
        pulse(1);
        wait_done(1, "t5");
        // start during MEASURE and ACCUM is ignored
        do_reset();
        mode = 1;
        dsel = 3;
        q2.push_back('{20, 1'b0, 1'b0});
        pulse(1);
        wait_lo2("t6");
        st2 = 1;
        @(negedge clk);
        st2 = 0;
        repeat (5) @(negedge clk);
        st2 = 1;
        @(negedge clk);
        st2 = 0;
        wait_done(1, "t6");
        // toggling return holds ARM until quiet
        do_reset();
        mode = 3;
        q0.push_back('{2, 1'b0, 1'b1});
        pulse(0);
        repeat (20) @(negedge clk);
        chk("t6_arm_hold_lo", 32'(lo0), 0);
        chk("t6_arm_hold_busy", 32'(busy0), 1);
        mode = 0;
        repeat (3) @(negedge clk);
        chk("t6_settle_wait", 32'(lo0), 0);
        wait_done(0, "t6b");
        repeat (2) @(negedge clk);
        chk("q0_drain", 32'(q0.size()), 0);
        chk("q2_drain", 32'(q2.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/delaychain_meter.md
Name: delaychain_meter

Overview:
- Launch-and-capture controller for a cascaded delay-chain test structure.
- Drives the chain input with alternating edges, synchronizes the chain output and counts clk cycles until the launched edge returns.
- Accumulates 2^LOG_RUNS runs and presents the sum with done/timeout status.
- Sits in the tile top beside the chain; the chain input is driven by launch_out and the chain output feeds chain_ret.

Parameters:
- CNT_W, 16, width of the per-run cycle counter.
- LOG_RUNS, 2, log2 of the number of runs summed per measurement (0 means a single run).
- TIMEOUT_CYC, 4000, per-run cycle limit for the ARM and MEASURE states; must be less than 2^CNT_W.
- SETTLE, 4, number of consecutive quiet cycles required in ARM before a launch.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, single-cycle request to begin a measurement; sampled only in IDLE and DONE.
- chain_ret, input, 1, asynchronous return from the chain end.
- launch_out, output, 1, registered drive to the chain input.
- busy, output, 1, high in ARM, LAUNCH, MEASURE and ACCUM.
- done, output, 1, high in DONE; held until the next accepted start or reset.
- timeout, output, 1, sticky per measurement; valid when done=1.
- result, output, CNT_W+LOG_RUNS, sum of per-run counts; valid when done=1.

Behaviour:
- Reset: one clock and synchronous active-high reset; rst is sampled on the rising clk edge.
- Reset values:
  - state=IDLE; launch_out=0; busy=0; done=0; timeout=0; result=0.
  - Synchronizer flops=0; run index=0; counters=0.
  - Reset wins over every other event and aborts any run in progress. launch_out returns to 0 in the same edge.
- Synchronizer: two flops, s1<=chain_ret, s2<=s1. Only s2 is used. No combinational path from chain_ret to any output.
- IDLE / DONE, start=1:
  - Clear result, timeout and run index.
  - done<=0; go to ARM.
  - start in any other state is ignored.
- ARM (quiet check):
  - quiet counter increments while s2==launch_out and clears otherwise.
  - When quiet reaches SETTLE, go to LAUNCH.
  - A separate arm counter increments every cycle in ARM. At TIMEOUT_CYC: timeout<=1, go to DONE. result keeps the runs already accumulated.
- LAUNCH, one cycle:
  - launch_out<=~launch_out; run counter<=0; go to MEASURE.
  - Edges alternate rising/falling across runs.
- MEASURE, each edge:
  - If s2!=launch_out: count<=count+1.
  - Else: go to ACCUM.
  - If count reaches TIMEOUT_CYC: timeout<=1, add TIMEOUT_CYC to result, go to DONE; the remaining runs are skipped.
- Latency definition: the count includes the 2-cycle synchronizer latency. A zero-delay loopback (chain_ret tied to launch_out) yields count=2. A return delayed by D whole cycles yields 2+D.
- ACCUM, one cycle:
  - result<=result+count, zero-extended to CNT_W+LOG_RUNS; no overflow is possible by construction.
  - If run index==2^LOG_RUNS-1, go to DONE; else increment run index and go to ARM.
- DONE:
  - done=1; result and timeout held stable.
  - launch_out holds its last level and is not returned to 0.
- Glitches: chain_ret glitches shorter than a clk period may or may not be captured. Any captured return ends the run; no filtering is applied.

Test Plan:
1. LOG_RUNS=0, chain_ret=launch_out (combinational loopback), pulse start:
   - done rises with result=2 and timeout=0.
   - launch_out ends at 1.
2. LOG_RUNS=0, bench delays launch_out by 5 clk cycles into chain_ret:
   - result=7.
   - A second start gives result=7 with launch_out ending at 0, confirming the falling-edge run.
3. LOG_RUNS=2, 3-cycle bench delay:
   - result=20 (4×5).
   - launch_out toggles exactly 4 times and ends at 0.
   - busy is high from the cycle after start until the cycle done rises.
4. TIMEOUT_CYC=100, chain_ret stuck at 0:
   - Run 1: MEASURE times out, so done=1, timeout=1, result=100.
   - Next start, launch_out=1 with return stuck at 0: ARM never settles, so after 100 ARM cycles done=1, timeout=1, result=0.
5. Assert rst for 1 cycle mid-MEASURE in test 3:
   - Next edge: busy=0, done=0, launch_out=0, result=0.
   - A following start with loopback gives result=8 with LOG_RUNS=2.
6. Pulse start during MEASURE and again during ACCUM:
   - Both are ignored; the final result is unchanged versus test 3 (20).
   - A start with chain_ret toggling every cycle in ARM holds ARM until it is quiet for SETTLE cycles.
